regfile: RTL and testbench

- General-purpose register file for the MIPS32 core datapath: 32 registers x 32 bits, two combinational read ports, one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (rs1/rs2 addresses) and writeback (rd, write_data, reg_write_en).

---
 rtl/mips_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 31 +++
 rtl/regfile.sv | 68 ++++++
 tb/tb_regfile.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath constants and types.
// Used by regfile and its read-port helper.
package mips_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     word_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-register masking and,
// with REGFILE_BYPASS_EN, writeback-to-decode forwarding.
module regfile_rd_port #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] stored,
`ifdef REGFILE_BYPASS_EN
   input  logic              wr_fire,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
`endif
   output logic [DATA_W-1:0] data
);

   import mips_pkg::*;

   // $0 reads zero; a same-cycle write to addr wins when bypassing
   always_comb begin
      data = '0;
      if (addr != ADDR_W'(REG_ZERO)) begin
         data = stored;
`ifdef REGFILE_BYPASS_EN
         if (wr_fire && (wr_addr == addr))
            data = wr_data;
`endif
      end
   end

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module regfile #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write_en,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   import mips_pkg::*;

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NREGS];
   logic              wr_fire;

   // a write only lands outside reset and never on $0
   always_comb begin
      wr_fire = reg_write_en && !rst && (rd != ADDR_W'(REG_ZERO));
   end

   // storage: reset clears everything and drops any concurrent write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= '0;
      end else if (wr_fire) begin
         mem[rd] <= write_data;
      end
   end

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd1 (
      .addr    (rs1),
      .stored  (mem[rs1]),
`ifdef REGFILE_BYPASS_EN
      .wr_fire (wr_fire),
      .wr_addr (rd),
      .wr_data (write_data),
`endif
      .data    (read_data1)
   );

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd2 (
      .addr    (rs2),
      .stored  (mem[rs2]),
`ifdef REGFILE_BYPASS_EN
      .wr_fire (wr_fire),
      .wr_addr (rd),
      .wr_data (write_data),
`endif
      .data    (read_data2)
   );

endmodule

// File: tb/tb_regfile.sv
// Directed plus random checks of regfile against an array model.
// Honors REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] write_data;
   logic        reg_write_en;
   logic [31:0] read_data1;
   logic [31:0] read_data2;

   int vectors;
   int miscompares;

   logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile dut (
      .clk          (clk),
      .rst          (rst),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .write_data   (write_data),
      .reg_write_en (reg_write_en),
      .read_data1   (read_data1),
      .read_data2   (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected read value given the model and the current inputs
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0)
         return 32'h0;
      if (BYP && reg_write_en && !rst && rd == a)
         return write_data;
      return model[a];
   endfunction

   // one rising edge; model absorbs what the inputs ask for
   task automatic cyc();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++)
            model[i] = 32'h0;
      end else if (reg_write_en && rd != 5'd0) begin
         model[rd] = write_data;
      end
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag,
                      input logic [4:0] a1,
                      input logic [4:0] a2);
      rs1 = a1;
      rs2 = a2;
      #1;
      check({tag, ".p1"}, read_data1, exp_read(a1));
      check({tag, ".p2"}, read_data2, exp_read(a2));
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      for (int i = 0; i < 32; i++)
         model[i] = 32'hx;
      rst          = 1'b1;
      reg_write_en = 1'b0;
      rd           = 5'd0;
      write_data   = 32'h0;
      rs1          = 5'd0;
      rs2          = 5'd0;
      cyc();
      rst = 1'b0;

      chk("reset", 5'd5, 5'd31);
      check("reset.lit", read_data2, 32'h0);
      chk("zero", 5'd0, 5'd0);

      reg_write_en = 1'b1;
      rd           = 5'd1;
      write_data   = 32'hDEADBEEF;
      cyc();
      reg_write_en = 1'b0;
      chk("wr1", 5'd1, 5'd0);
      check("wr1.lit", read_data1, 32'hDEADBEEF);

      reg_write_en = 1'b1;
      rd           = 5'd0;
      write_data   = 32'h0BADC0DE;
      cyc();
      reg_write_en = 1'b0;
      chk("wr0", 5'd0, 5'd1);
      check("wr0.lit", read_data2, 32'hDEADBEEF);

      reg_write_en = 1'b1;
      rd           = 5'd2;
      write_data   = 32'hCAFEBABE;
      cyc();
      reg_write_en = 1'b0;
      chk("dual", 5'd1, 5'd2);
      check("dual.lit", read_data2, 32'hCAFEBABE);
      chk("same", 5'd2, 5'd2);

      rd         = 5'd3;
      write_data = 32'h12345678;
      cyc();
      chk("noen", 5'd3, 5'd3);
      check("noen.lit", read_data1, 32'h0);

      reg_write_en = 1'b1;
      rd           = 5'd4;
      write_data   = 32'h11112222;
      cyc();
      rst        = 1'b1;
      write_data = 32'h55AA55AA;
      cyc();
      rst          = 1'b0;
      reg_write_en = 1'b0;
      chk("rstpri", 5'd4, 5'd1);
      check("rstpri.lit", read_data1, 32'h0);

      reg_write_en = 1'b1;
      rd           = 5'd5;
      write_data   = 32'hA5A5A5A5;
      chk("byp.pre", 5'd5, 5'd0);
      check("byp.lit", read_data1, BYP ? 32'hA5A5A5A5 : 32'h0);
      cyc();
      reg_write_en = 1'b0;
      chk("byp.post", 5'd5, 5'd0);
      check("byp.post.lit", read_data1, 32'hA5A5A5A5);

      for (int n = 0; n < 400; n++) begin
         rst          = ($urandom_range(31) == 0);
         reg_write_en = $urandom_range(1);
         rd           = 5'($urandom_range(31));
         write_data   = $urandom;
         if ($urandom_range(3) == 0)
            chk("rnd.pre", rd, 5'($urandom_range(31)));
         else
            chk("rnd.pre", 5'($urandom_range(31)),
                5'($urandom_range(31)));
         cyc();
         chk("rnd.post", rs1, rs2);
      end

      rst          = 1'b0;
      reg_write_en = 1'b0;
      for (int a = 0; a < 32; a++)
         chk("sweep", 5'(a), 5'(31 - a));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
